// File: rtl/nexys_starship_game_ctrl.sv
// ---------------------------------------------------------------------------
// nexys_starship_game_ctrl: starship game sequencer (lives, levels, pause, banner)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nexys_starship_game_ctrl #(
   parameter int NUM_LIVES     = 3,
   parameter int NUM_LEVELS    = 4,
   parameter int BANNER_CYCLES = 100000000
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       BtnU,
   input  logic       BtnC,
   input  logic       hit,
   input  logic       level_clear,
   output logic       q_Init,
   output logic       q_Play,
   output logic       q_Pause,
   output logic       q_LevelUp,
   output logic       q_GameOver,
   output logic       play_flag,
   output logic [3:0] lives,
   output logic [3:0] level,
   output logic       win
);

   localparam int         C_CW       = (BANNER_CYCLES > 2) ? $clog2(BANNER_CYCLES) : 1;
   localparam logic [3:0] C_LIVES    = 4'(NUM_LIVES);
   localparam logic [3:0] C_LAST_LVL = 4'(NUM_LEVELS - 1);
   localparam logic [C_CW-1:0] C_CNT_LOAD = C_CW'(BANNER_CYCLES - 1);

   typedef enum logic [2:0] {
      S_INIT     = 3'd0,
      S_PLAY     = 3'd1,
      S_PAUSE    = 3'd2,
      S_LEVELUP  = 3'd3,
      S_GAMEOVER = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      lives_q, lives_d;
   logic [3:0]      level_q, level_d;
   logic            win_q, win_d;
   logic [C_CW-1:0] cnt_q, cnt_d;
   logic [4:0]      flags_q, flags_d;
   logic            play_q, play_d;
   logic            btnu_prev_q, btnc_prev_q;

   logic btnu_edge, btnc_edge;
   assign btnu_edge = BtnU & ~btnu_prev_q;
   assign btnc_edge = BtnC & ~btnc_prev_q;

   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      level_d = level_q;
      win_d   = win_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_INIT: begin
            if (btnu_edge) begin
               state_d = S_PLAY;
               lives_d = C_LIVES;
               level_d = 4'd0;
               win_d   = 1'b0;
            end
         end
         S_PLAY: begin
            // a hit outranks a simultaneous level_clear, both outrank pause
            if (hit) begin
               if (lives_q <= 4'd1) begin
                  lives_d = 4'd0;
                  win_d   = 1'b0;
                  state_d = S_GAMEOVER;
               end else begin
                  lives_d = lives_q - 4'd1;
               end
            end else if (level_clear) begin
               if (level_q >= C_LAST_LVL) begin
                  win_d   = 1'b1;
                  state_d = S_GAMEOVER;
               end else begin
                  level_d = level_q + 4'd1;
                  cnt_d   = C_CNT_LOAD;
                  state_d = S_LEVELUP;
               end
            end else if (btnc_edge) begin
               state_d = S_PAUSE;
            end
         end
         S_PAUSE: begin
            if (btnc_edge || btnu_edge) state_d = S_PLAY;
         end
         S_LEVELUP: begin
            if (cnt_q == '0) state_d = S_PLAY;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_GAMEOVER: begin
            if (btnu_edge) begin
               state_d = S_INIT;
               lives_d = 4'd0;
               level_d = 4'd0;
               win_d   = 1'b0;
            end
         end
         default: begin
            state_d = S_INIT;
            lives_d = 4'd0;
            level_d = 4'd0;
            win_d   = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // flags are registered from the next state so they are one-hot even if state_q is corrupted
   always_comb begin
      flags_d = 5'b10000;
      play_d  = 1'b0;
      unique case (state_d)
         S_PLAY:     begin flags_d = 5'b01000; play_d = 1'b1; end
         S_PAUSE:    begin flags_d = 5'b00100; play_d = 1'b1; end
         S_LEVELUP:  begin flags_d = 5'b00010; play_d = 1'b1; end
         S_GAMEOVER: begin flags_d = 5'b00001; end
         default:    begin flags_d = 5'b10000; end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= S_INIT;
         lives_q     <= 4'd0;
         level_q     <= 4'd0;
         win_q       <= 1'b0;
         cnt_q       <= '0;
         flags_q     <= 5'b10000;
         play_q      <= 1'b0;
         btnu_prev_q <= 1'b1;
         btnc_prev_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         level_q     <= level_d;
         win_q       <= win_d;
         cnt_q       <= cnt_d;
         flags_q     <= flags_d;
         play_q      <= play_d;
         btnu_prev_q <= BtnU;
         btnc_prev_q <= BtnC;
      end
   end

   assign {q_Init, q_Play, q_Pause, q_LevelUp, q_GameOver} = flags_q;
   assign play_flag = play_q;
   assign lives     = lives_q;
   assign level     = level_q;
   assign win       = win_q;

endmodule

`default_nettype wire

// File: tb/tb_nexys_starship_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nexys_starship_game_ctrl: directed self-checking bench for the game sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_nexys_starship_game_ctrl;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       BtnU = 1'b0, BtnC = 1'b0, hit = 1'b0, level_clear = 1'b0;
   logic       q_Init, q_Play, q_Pause, q_LevelUp, q_GameOver, play_flag, win;
   logic [3:0] lives, level;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [4:0] F_INIT = 5'b10000;
   localparam logic [4:0] F_PLAY = 5'b01000;
   localparam logic [4:0] F_PAUS = 5'b00100;
   localparam logic [4:0] F_LVUP = 5'b00010;
   localparam logic [4:0] F_OVER = 5'b00001;

   nexys_starship_game_ctrl #(
      .NUM_LIVES    (3),
      .NUM_LEVELS   (2),
      .BANNER_CYCLES(4)
   ) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .BtnU       (BtnU),
      .BtnC       (BtnC),
      .hit        (hit),
      .level_clear(level_clear),
      .q_Init     (q_Init),
      .q_Play     (q_Play),
      .q_Pause    (q_Pause),
      .q_LevelUp  (q_LevelUp),
      .q_GameOver (q_GameOver),
      .play_flag  (play_flag),
      .lives      (lives),
      .level      (level),
      .win        (win)
   );

   always #5 Clk = ~Clk;

   logic [4:0] flags;
   assign flags = {q_Init, q_Play, q_Pause, q_LevelUp, q_GameOver};

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [4:0] f, input logic [3:0] lv,
                          input logic [3:0] lvl, input logic w, input logic pf);
      chk({tag, ".flags"}, 32'(flags), 32'(f));
      chk({tag, ".lives"}, 32'(lives), 32'(lv));
      chk({tag, ".level"}, 32'(level), 32'(lvl));
      chk({tag, ".win"},   32'(win),   32'(w));
      chk({tag, ".play"},  32'(play_flag), 32'(pf));
   endtask

   initial begin
      #12;
      chk_all("reset", F_INIT, 4'd0, 4'd0, 1'b0, 1'b0);
      tick();
      Reset_n = 1'b1;
      tick(); tick();
      chk_all("idle", F_INIT, 4'd0, 4'd0, 1'b0, 1'b0);

      // start game
      BtnU = 1'b1; tick(); BtnU = 1'b0;
      chk_all("start", F_PLAY, 4'd3, 4'd0, 1'b0, 1'b1);

      // three hits to game over
      hit = 1'b1; tick(); hit = 1'b0;
      chk_all("hit1", F_PLAY, 4'd2, 4'd0, 1'b0, 1'b1);
      hit = 1'b1; tick(); hit = 1'b0;
      chk_all("hit2", F_PLAY, 4'd1, 4'd0, 1'b0, 1'b1);
      hit = 1'b1; tick(); hit = 1'b0;
      chk_all("hit3", F_OVER, 4'd0, 4'd0, 1'b0, 1'b0);
      hit = 1'b1; level_clear = 1'b1; BtnC = 1'b1; tick();
      hit = 1'b0; level_clear = 1'b0; BtnC = 1'b0; tick();
      chk_all("over_ignore", F_OVER, 4'd0, 4'd0, 1'b0, 1'b0);
      BtnU = 1'b1; tick(); BtnU = 1'b0;
      chk_all("back_init", F_INIT, 4'd0, 4'd0, 1'b0, 1'b0);
      tick();

      // new game, level up banner lasts 4 cycles
      BtnU = 1'b1; tick(); BtnU = 1'b0;
      chk_all("start2", F_PLAY, 4'd3, 4'd0, 1'b0, 1'b1);
      level_clear = 1'b1; tick(); level_clear = 1'b0;
      chk_all("lvlup", F_LVUP, 4'd3, 4'd1, 1'b0, 1'b1);
      BtnC = 1'b1; hit = 1'b1;
      for (int i = 1; i < 4; i++) begin
         tick();
         chk($sformatf("banner%0d", i), 32'(flags), 32'(F_LVUP));
         BtnC = 1'b0; hit = 1'b0;
      end
      tick();
      chk_all("banner_end", F_PLAY, 4'd3, 4'd1, 1'b0, 1'b1);

      // hit wins over level_clear
      hit = 1'b1; level_clear = 1'b1; tick(); hit = 1'b0; level_clear = 1'b0;
      chk_all("hit_prio", F_PLAY, 4'd2, 4'd1, 1'b0, 1'b1);

      // BtnC held 10 cycles gives a single pause entry
      BtnC = 1'b1; tick();
      chk_all("pause", F_PAUS, 4'd2, 4'd1, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) tick();
      chk("pause_held", 32'(flags), 32'(F_PAUS));
      BtnC = 1'b0; tick();
      hit = 1'b1; level_clear = 1'b1; tick(); hit = 1'b0; level_clear = 1'b0;
      chk_all("pause_hit", F_PAUS, 4'd2, 4'd1, 1'b0, 1'b1);
      BtnU = 1'b1; tick(); BtnU = 1'b0;
      chk_all("resume", F_PLAY, 4'd2, 4'd1, 1'b0, 1'b1);
      tick();

      // final level cleared: win
      level_clear = 1'b1; tick(); level_clear = 1'b0;
      chk_all("win", F_OVER, 4'd2, 4'd1, 1'b1, 1'b0);
      tick();
      chk_all("win_hold", F_OVER, 4'd2, 4'd1, 1'b1, 1'b0);
      BtnU = 1'b1; tick(); BtnU = 1'b0;
      chk_all("clear_init", F_INIT, 4'd0, 4'd0, 1'b0, 1'b0);
      tick();

      // BtnU held across reset release is not a press
      BtnU = 1'b1; Reset_n = 1'b0; #2; Reset_n = 1'b1;
      tick(); tick(); tick();
      chk_all("held_btn", F_INIT, 4'd0, 4'd0, 1'b0, 1'b0);
      BtnU = 1'b0; tick();
      chk("held_release", 32'(flags), 32'(F_INIT));
      BtnU = 1'b1; tick(); BtnU = 1'b0;
      chk_all("repress", F_PLAY, 4'd3, 4'd0, 1'b0, 1'b1);

      // asynchronous reset in the middle of the banner
      level_clear = 1'b1; tick(); level_clear = 1'b0;
      tick();
      chk("pre_rst_lvup", 32'(flags), 32'(F_LVUP));
      #1 Reset_n = 1'b0; #1;
      chk_all("async_rst", F_INIT, 4'd0, 4'd0, 1'b0, 1'b0);
      tick();
      Reset_n = 1'b1;
      tick();
      BtnU = 1'b1; tick(); BtnU = 1'b0;
      chk_all("after_rst", F_PLAY, 4'd3, 4'd0, 1'b0, 1'b1);
      tick(); tick();
      chk_all("no_residue", F_PLAY, 4'd3, 4'd0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/nexys_starship_game_ctrl.md
NEXYS_STARSHIP_GAME_CTRL -- requirements
Module: nexys_starship_game_ctrl

Interface
REQ-001 SHALL have parameter NUM_LIVES, default 3, lives granted at game start (1..15).
REQ-002 SHALL have parameter NUM_LEVELS, default 4, levels per game (1..15); level indices 0..NUM_LEVELS-1.
REQ-003 SHALL have parameter BANNER_CYCLES, default 100000000, LEVELUP dwell in clocks (>=2; 1 s at 100 MHz).
REQ-004 SHALL have port Clk  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port Reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port BtnU  input  1  debounced start/resume/acknowledge button, level-sensitive.
REQ-007 SHALL have port BtnC  input  1  debounced pause button, level-sensitive.
REQ-008 SHALL have port hit  input  1  ship-hit event, one-cycle pulse.
REQ-009 SHALL have port level_clear  input  1  level-completed event, one-cycle pulse.
REQ-010 SHALL have ports q_Init, q_Play, q_Pause, q_LevelUp, q_GameOver  output  1 each  one-hot state flags.
REQ-011 SHALL have port play_flag  output  1  high while a game is in progress.
REQ-012 SHALL have port lives  output  4  remaining lives.
REQ-013 SHALL have port level  output  4  current level index.
REQ-014 SHALL have port win  output  1  high in GAMEOVER when the final level was cleared.

Function
REQ-015 SHALL detect button presses as rising edges: edge = button & ~button_prev, with button_prev registered every cycle.
REQ-016 SHALL implement states INIT, PLAY, PAUSE, LEVELUP, GAMEOVER; exactly one q_* flag high at all times.
REQ-017 SHALL register all outputs; a qualifying input sampled at edge k takes effect at edge k (visible after edge k).
REQ-018 INIT: BtnU edge -> PLAY; lives<=NUM_LIVES, level<=0, win<=0 on the same edge.
REQ-019 PLAY: hit -> lives decremented; if lives==1, lives<=0 and -> GAMEOVER, win<=0.
REQ-020 PLAY: level_clear with level==NUM_LEVELS-1 -> GAMEOVER, win<=1; otherwise -> LEVELUP, level incremented, banner counter loaded with BANNER_CYCLES-1.
REQ-021 PLAY: hit and level_clear in the same cycle -> hit processed, level_clear discarded.
REQ-022 PLAY: BtnC edge with no hit/level_clear -> PAUSE; hit/level_clear take priority over BtnC.
REQ-023 PAUSE: BtnC edge or BtnU edge -> PLAY; hit and level_clear ignored.
REQ-024 LEVELUP: counter decrements each cycle; on cycle counter==0 -> PLAY; exactly BANNER_CYCLES cycles in LEVELUP; buttons, hit, level_clear ignored.
REQ-025 GAMEOVER: lives, level, win held; BtnU edge -> INIT; hit, level_clear, BtnC ignored.
REQ-026 INIT entry from GAMEOVER SHALL clear lives, level and win to 0.
REQ-027 play_flag SHALL be 1 in PLAY, PAUSE, LEVELUP; 0 in INIT, GAMEOVER.
REQ-028 lives SHALL never underflow below 0; level SHALL never exceed NUM_LEVELS-1.
REQ-029 Unreachable state encodings SHALL transition to INIT on the next edge with lives/level/win cleared.
REQ-030 Counter width SHALL be $clog2(BANNER_CYCLES) bits, minimum 1.

Reset
REQ-031 Reset_n low SHALL immediately force state INIT, lives=0, level=0, win=0, play_flag=0, counter=0.
REQ-032 Reset_n low SHALL set both button_prev registers to 1, so a button held across reset release is not a press.
REQ-033 Reset asserted mid-LEVELUP or mid-PAUSE SHALL abandon the game with no residual counter or flag state.
REQ-034 Reset deassertion SHALL be used as-is; synchronisation is the parent's responsibility.

Verification
REQ-035 Reset, BtnU pulse -> q_Play=1, lives=3, level=0, play_flag=1 one edge later.
REQ-036 In PLAY, three hit pulses -> lives 2,1,0; after third: q_GameOver=1, win=0, play_flag=0; BtnU -> q_Init=1, lives=0.
REQ-037 BANNER_CYCLES=4: level_clear at level 0 -> q_LevelUp=1, level=1 for exactly 4 cycles, then q_Play=1.
REQ-038 NUM_LEVELS=2 at level 1: hit and level_clear same cycle -> lives decremented, state PLAY, level 1; next lone level_clear -> q_GameOver=1, win=1.
REQ-039 BtnC held high 10 cycles in PLAY -> single PAUSE entry; hit during PAUSE -> lives unchanged; BtnU edge -> PLAY.
REQ-040 BtnU held through Reset_n release -> stays INIT until BtnU falls and rises again; Reset_n low during LEVELUP -> q_Init=1 asynchronously.
